iis_tx_frame_scheduler: RTL and testbench

//  Feeds stereo frames to iis_write_logic from two requesters (A, B) sharing one I2S transmitter.

---
 rtl/iis_tx_frame_if.sv | 37 +++
 rtl/iis_tx_frame_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_iis_tx_frame_scheduler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iis_tx_frame_if.sv
// ---------------------------------------------------------------------------
// iis_tx_frame_if
//   Requester-side bundle for iis_tx_frame_scheduler: two independent
//   valid/ready frame channels (A and B), each carrying one stereo frame.
//
//   a_valid / b_valid   requester has a frame to offer
//   a_ready / b_ready   scheduler accepts the frame this cycle
//   a_ldata / b_ldata   left sample  (DW bits)
//   a_rdata / b_rdata   right sample (DW bits)
//
//   master : the audio sources (drive valid + data, observe ready)
//   slave  : the scheduler     (observe valid + data, drive ready)
// ---------------------------------------------------------------------------
interface iis_tx_frame_if #(
  parameter int DW = 24
);
  logic          a_valid;
  logic          a_ready;
  logic [DW-1:0] a_ldata;
  logic [DW-1:0] a_rdata;
  logic          b_valid;
  logic          b_ready;
  logic [DW-1:0] b_ldata;
  logic [DW-1:0] b_rdata;

  modport master (
    output a_valid, a_ldata, a_rdata,
    output b_valid, b_ldata, b_rdata,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_ldata, a_rdata,
    input  b_valid, b_ldata, b_rdata,
    output a_ready, b_ready
  );
endinterface

// File: rtl/iis_tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// iis_tx_frame_scheduler
//   Feeds stereo frames to iis_write_logic from two requesters sharing one
//   I2S transmitter. Pushes from A/B are round-robin arbitrated into a small
//   frame FIFO; one frame is popped per lrclk rising edge and held on
//   ldata/rdata for the whole frame. An FSM handles start-up priming, the
//   orderly stop at a frame boundary, and underrun reporting.
//
// Ports
//   clk_100m      system clock, rising edge
//   rst           synchronous reset, active-high
//   lrclk         word clock (clk_100m-synchronous)
//   enable        run request
//   req           requester A/B valid/ready channels (slave modport)
//   ldata, rdata  held frame to iis_write_logic
//   en            transmitter enable
//   fifo_level    frames stored, 0..2**AW
//   underrun      sticky flag: a frame was due while the FIFO was empty
//   clr_underrun  clears underrun
// ---------------------------------------------------------------------------
module iis_tx_frame_scheduler #(
  parameter int DW        = 24,
  parameter int AW        = 2,
  parameter int PRIME_LVL = 2,
  parameter int HOLD_LAST = 0
) (
  input  logic          clk_100m,
  input  logic          rst,
  input  logic          lrclk,
  input  logic          enable,
  iis_tx_frame_if.slave req,
  output logic [DW-1:0] ldata,
  output logic [DW-1:0] rdata,
  output logic          en,
  output logic [AW:0]   fifo_level,
  output logic          underrun,
  input  logic          clr_underrun
);

  localparam int            DEPTH    = 2**AW;
  localparam int            LW       = AW + 1;
  localparam logic [AW:0]   FULL_LVL = LW'(DEPTH);
  localparam logic [AW:0]   PRIME_C  = LW'(PRIME_LVL);
  localparam logic [AW:0]   LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_STOP
  } state_e;

  typedef enum logic {
    RR_A,
    RR_B
  } rr_e;

  state_e          state_q, state_d;
  rr_e             rr_q, rr_d;
  logic            lrclk_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [DW-1:0]   ldata_q, ldata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            underrun_q, underrun_d;

  logic [2*DW-1:0] mem_q [DEPTH];

  logic            tick;
  logic            push_ok;
  logic            full;
  logic            empty;
  logic            grant_a;
  logic            grant_b;
  logic            push;
  logic [2*DW-1:0] push_frame;
  logic            pop;
  logic            underrun_set;
  logic            flush;
  logic            zero_out;

  // One-cycle pulse at each lrclk rising edge marks the frame boundary.
  assign tick  = lrclk & ~lrclk_q;
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);

  // Arbitration. full uses the registered level, so a frame is never pushed
  // into a full FIFO even when a pop frees a slot in the same cycle.
  assign push_ok    = (state_q == S_PRIME) || (state_q == S_RUN);
  assign grant_a    = push_ok & req.a_valid & (~req.b_valid | (rr_q == RR_A));
  assign grant_b    = push_ok & req.b_valid & ~grant_a;
  assign req.a_ready = grant_a & ~full;
  assign req.b_ready = grant_b & ~full;
  assign push       = (grant_a | grant_b) & ~full;
  assign push_frame = grant_a ? {req.a_ldata, req.a_rdata}
                              : {req.b_ldata, req.b_rdata};

  // NOTE: every signal written in an always_comb gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    underrun_set = 1'b0;
    flush        = 1'b0;
    zero_out     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        flush = 1'b1;
        if (enable) state_d = S_PRIME;
      end
      S_PRIME: begin
        if (!enable) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else if (tick && (level_q >= PRIME_C)) begin
          pop     = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A same-cycle push never bypasses an empty FIFO: the frame is
        // stored and this boundary is still an underrun.
        if (tick) begin
          if (empty) underrun_set = 1'b1;
          else       pop          = 1'b1;
        end
        if (!enable) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick) begin
          state_d  = S_IDLE;
          flush    = 1'b1;
          zero_out = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign en = (state_q == S_RUN) || (state_q == S_STOP);

  always_comb begin
    rr_d       = rr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ldata_d    = ldata_q;
    rdata_d    = rdata_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      rr_d     = grant_a ? RR_B : RR_A;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // Output frame only moves at a frame boundary.
    if (pop) begin
      {ldata_d, rdata_d} = mem_q[rd_ptr_q];
    end else if (underrun_set && (HOLD_LAST == 0)) begin
      ldata_d = '0;
      rdata_d = '0;
    end
    if (zero_out) begin
      ldata_d = '0;
      rdata_d = '0;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    // A fresh underrun outranks a simultaneous clear.
    underrun_d = underrun_set | (underrun_q & ~clr_underrun);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_q       <= RR_A;
      lrclk_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ldata_q    <= '0;
      rdata_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lrclk_q    <= lrclk;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ldata_q    <= ldata_d;
      rdata_q    <= rdata_d;
      underrun_q <= underrun_d;
    end
  end

  // NOTE: the frame storage has no reset; the pointers and level define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk_100m) begin
    if (push) mem_q[wr_ptr_q] <= push_frame;
  end

  assign ldata      = ldata_q;
  assign rdata      = rdata_q;
  assign fifo_level = level_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_iis_tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_iis_tx_frame_scheduler
//   Directed bench for iis_tx_frame_scheduler (DW=24, AW=2, PRIME_LVL=2,
//   HOLD_LAST=0). Inputs are driven at the falling edge; outputs are read
//   at the falling edge (registered) or 1 ns after driving (ready).
//   Accepted frames go into a scoreboard queue and are compared against
//   ldata/rdata after each frame boundary that should pop.
// ---------------------------------------------------------------------------
module tb_iis_tx_frame_scheduler;

  localparam int DW = 24;
  localparam int AW = 2;

  logic          clk_100m = 1'b0;
  logic          rst;
  logic          lrclk;
  logic          enable;
  logic          clr_underrun;
  logic [DW-1:0] ldata;
  logic [DW-1:0] rdata;
  logic          en;
  logic [AW:0]   fifo_level;
  logic          underrun;

  iis_tx_frame_if #(.DW(DW)) req_if ();

  iis_tx_frame_scheduler #(
    .DW(DW), .AW(AW), .PRIME_LVL(2), .HOLD_LAST(0)
  ) dut (
    .clk_100m     (clk_100m),
    .rst          (rst),
    .lrclk        (lrclk),
    .enable       (enable),
    .req          (req_if),
    .ldata        (ldata),
    .rdata        (rdata),
    .en           (en),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
  );

  always #5 clk_100m = ~clk_100m;

  int unsigned   n_total = 0;
  int unsigned   n_pass  = 0;
  int unsigned   n_fail  = 0;
  int            exp_lvl = 0;
  logic [DW-1:0] exp_l   = '0;
  logic [DW-1:0] exp_r   = '0;
  logic [DW-1:0] a_l = '0, a_r = '0, b_l = '0, b_r = '0;
  logic [2*DW-1:0] sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, check the combinational
  // readies, record expected acceptances, advance to the next falling edge.
  task automatic cyc(input logic av, input logic bv, input logic lr, input logic clr,
                     input logic exp_ar, input logic exp_br);
    req_if.a_valid = av;
    req_if.a_ldata = a_l;
    req_if.a_rdata = a_r;
    req_if.b_valid = bv;
    req_if.b_ldata = b_l;
    req_if.b_rdata = b_r;
    lrclk          = lr;
    clr_underrun   = clr;
    #1;
    check("a_ready", 64'(req_if.a_ready), 64'(exp_ar));
    check("b_ready", 64'(req_if.b_ready), 64'(exp_br));
    if (!rst) begin
      if (av && exp_ar) begin
        sb.push_back({a_l, a_r});
        exp_lvl++;
      end else if (bv && exp_br) begin
        sb.push_back({b_l, b_r});
        exp_lvl++;
      end
    end
    @(negedge clk_100m);
  endtask

  task automatic lows(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called right after a tick edge that should have popped a frame.
  task automatic expect_pop(input string tag);
    logic [2*DW-1:0] f;
    check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      f     = sb.pop_front();
      exp_l = f[2*DW-1:DW];
      exp_r = f[DW-1:0];
      exp_lvl--;
    end
    check({tag, "_ldata"}, 64'(ldata), 64'(exp_l));
    check({tag, "_rdata"}, 64'(rdata), 64'(exp_r));
    check({tag, "_level"}, 64'(fifo_level), 64'(exp_lvl));
    check({tag, "_en"}, 64'(en), 64'd1);
  endtask

  initial begin
    rst            = 1'b1;
    enable         = 1'b0;
    lrclk          = 1'b0;
    clr_underrun   = 1'b0;
    req_if.a_valid = 1'b0;
    req_if.b_valid = 1'b0;
    req_if.a_ldata = '0;
    req_if.a_rdata = '0;
    req_if.b_ldata = '0;
    req_if.b_rdata = '0;
    @(negedge clk_100m);

    // 1: reset held 3 cycles, requesters valid -> nothing accepted.
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_ldata", 64'(ldata), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_en", 64'(en), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   // IDLE: no ready

    // 2: prime with two A frames, then two ticks pop them in order.
    enable = 1'b1;
    lows(1);
    a_l = 24'd1; a_r = 24'd2;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    a_l = 24'd3; a_r = 24'd4;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("prime_level", 64'(fifo_level), 64'd2);
    check("prime_en", 64'(en), 64'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_pop("pop1");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    lows(3);
    check("hold_ldata", 64'(ldata), 64'(exp_l));
    check("hold_rdata", 64'(rdata), 64'(exp_r));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_pop("pop2");
    lows(3);

    // 4: underrun at an empty tick; clear; set-wins-over-clear.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ur_flag", 64'(underrun), 64'd1);
    check("ur_ldata", 64'(ldata), 64'd0);
    check("ur_rdata", 64'(rdata), 64'd0);
    check("ur_en", 64'(en), 64'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ur_sticky", 64'(underrun), 64'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("ur_clear", 64'(underrun), 64'd0);
    lows(3);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("ur_set_wins", 64'(underrun), 64'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("ur_clear2", 64'(underrun), 64'd0);
    lows(3);

    // 3: B alone first (moves rr to A), then A and B contending.
    b_l = 24'h123456; b_r = 24'h654321;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_pop("pop_b");
    lows(3);
    a_l = 24'hAAAAAA; a_r = 24'hAAAAAA;
    b_l = 24'hBBBBBB; b_r = 24'hBBBBBB;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("full_level", 64'(fifo_level), 64'd4);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // full: both stalled
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);   // pop while full: still no push
    expect_pop("pop_full");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);   // slot freed, A's turn
    check("refill_level", 64'(fifo_level), 64'd4);
    lows(3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_pop("pop_b2");
    lows(3);
    a_l = 24'h111111; a_r = 24'h222222;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);   // push and pop same cycle
    expect_pop("pop_push_same");
    lows(3);

    // 5: enable drop in RUN -> STOP until next tick, then IDLE and flushed.
    enable = 1'b0;
    lows(1);
    check("stop_en", 64'(en), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   // pushes blocked in STOP
    check("stop_hold_ldata", 64'(ldata), 64'(exp_l));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    sb.delete();
    exp_lvl = 0;
    check("idle_en", 64'(en), 64'd0);
    check("idle_ldata", 64'(ldata), 64'd0);
    check("idle_rdata", 64'(rdata), 64'd0);
    check("idle_level", 64'(fifo_level), 64'd0);
    lows(3);

    // Priming boundary: one frame below PRIME_LVL does not start playback.
    enable = 1'b1;
    lows(1);
    a_l = 24'd5; a_r = 24'd6;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("underprime_en", 64'(en), 64'd0);
    check("underprime_level", 64'(fifo_level), 64'd1);
    check("underprime_ldata", 64'(ldata), 64'd0);
    lows(3);
    a_l = 24'd7; a_r = 24'd8;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    a_l = 24'd9; a_r = 24'd10;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_pop("pop_prime2");
    a_l = 24'd11; a_r = 24'd12;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("pre_rst_level", 64'(fifo_level), 64'd3);

    // 6: reset mid-frame with three frames stored.
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_rst_ldata", 64'(ldata), 64'd0);
    check("mid_rst_rdata", 64'(rdata), 64'd0);
    check("mid_rst_en", 64'(en), 64'd0);
    check("mid_rst_level", 64'(fifo_level), 64'd0);
    check("mid_rst_underrun", 64'(underrun), 64'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    sb.delete();
    lows(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
